scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Scan-chain load/unload and run controller for `accumulator_microcontroller`. It takes program/state bytes over a valid/ready stream and shifts them serially into the core's scan chain. At the same time it captures the bits leaving `scan_out` and returns them as a byte stream, so one session both loads a new image and unloads the old state. It then optionally runs the core by driving `proc_en` until `halt`. It sits between the chip-level host interface and the core's `scan_enable`/`scan_in`/`scan_out`/`proc_en`/`halt` pins.

## Interface
Parameters:
- `CHAIN_LEN`, 2136: total scan bits of the attached core. Must be a multiple of 8; `NBYTES = CHAIN_LEN/8`.
- `RUN_LIMIT`, 65535: maximum RUN cycles (watchdog build only); must be ≥1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; **synchronous, active-high**.
- `start`  in  1  begin session; sampled only in IDLE.
- `run_req`  in  1  sampled with `start`; 1 = enter RUN after load.
- `din`  in  8  load byte.
- `din_valid`  in  1  load byte valid.
- `din_ready`  out  1  load byte accepted when `din_valid && din_ready`.
- `dout`  out  8  captured (unloaded) byte.
- `dout_valid`  out  1  captured byte valid.
- `dout_ready`  in  1  captured byte consumed when `dout_valid && dout_ready`.
- `scan_enable`  out  1  to core `scan_enable`.
- `scan_in`  out  1  to core `scan_in`.
- `scan_out`  in  1  from core `scan_out`.
- `proc_en`  out  1  to core `proc_en`.
- `halt`  in  1  from core `halt`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse on return to IDLE.
- `timeout`  out  1  sticky; set when the watchdog fires, cleared by `start` or `rst`.

## Operation
- States: IDLE, FETCH, SHIFT, DRAIN, RUN.
- IDLE → FETCH on `start`. In the same cycle, latch `run_req`, clear the byte counter, clear `timeout`.
- FETCH:
  - `din_ready`=1.
  - On handshake, load `din` into an 8-bit shift register, clear the bit counter, and go to SHIFT.
- SHIFT, one bit per cycle for 8 cycles:
  - `scan_enable`=1 and `scan_in`=`shreg[0]` (LSB first).
  - The same cycle samples `scan_out` into `capreg` MSB and right-shifts `capreg`, so the first bit out lands in `dout[0]`.
  - After bit 7, go to DRAIN with `dout`=`capreg`.
- DRAIN:
  - `dout_valid`=1 and `scan_enable`=0; the chain holds while `dout_ready` is low.
  - On handshake, increment the byte counter.
  - If count=`NBYTES`: go to RUN if the latched `run_req`=1, else go to IDLE. Otherwise go to FETCH.
- RUN:
  - `proc_en`=1 and `scan_enable`=0.
  - Exit to IDLE when `halt`=1, sampled at a clock edge. `proc_en` drops the following cycle.
- Byte ordering: the first accepted byte ends up deepest in the chain (memory end). The first `dout` byte is the content previously nearest `scan_out`.
- `scan_enable` and `proc_en` are never high in the same cycle.
- Boundary conditions:
  - `start` while busy is ignored.
  - `din_valid` outside FETCH is ignored.
  - `halt` already high on RUN entry exits RUN after one cycle.
  - Byte counter width is `$clog2(NBYTES+1)`; no wrap is possible.
  - Reset mid-session returns to IDLE immediately. Chain contents are then undefined, and the host must start a new full session.

## Timing
- Reset values: `din_ready`=0, `dout`=0, `dout_valid`=0, `scan_enable`=0, `scan_in`=0, `proc_en`=0, `busy`=0, `done`=0, `timeout`=0.
- All outputs are registered or decoded from state only. There is no combinational path from `din_valid`, `dout_ready` or `halt` to any output.
- Per-byte latency is 1 cycle FETCH handshake + 8 SHIFT cycles + ≥1 DRAIN cycle. The minimum is 10 cycles/byte with the host always valid/ready.
- `done` is asserted in the first IDLE cycle after DRAIN or RUN.
- `scan_out` is sampled in the same cycle `scan_enable`=1, which is the pre-shift chain tail.

## Configuration
- Macro: `SCAN_SEQ_WATCHDOG_EN`.
- Defined:
  - A RUN cycle counter clears on RUN entry and increments each RUN cycle.
  - When the count reaches `RUN_LIMIT` without `halt`, the block sets `timeout`=1, drops `proc_en` and returns to IDLE with `done`.
  - `halt` and the limit in the same cycle: `halt` wins, so `timeout` stays 0.
- Undefined:
  - No counter is built and `RUN_LIMIT` is unused.
  - `timeout` is tied 0.
  - RUN lasts until `halt` only.

## Test plan
- **Basic load:** `CHAIN_LEN`=16, bench chain model preloaded with 0xA55A, `start` with `run_req`=0, `din`=0x3C then 0xC3, host always ready → `dout`=0x5A then 0xA5, model holds 0xC33C, `done` pulse, 20 cycles total.
- **Backpressure:** as above with `din_valid` low for 5 cycles and `dout_ready` low for 7 cycles → `scan_enable` stays 0 during both stalls, and chain and `dout` values are identical to the unstalled run.
- **Run to halt:** `run_req`=1, model raises `halt` 12 cycles after `proc_en` rises → `proc_en` high exactly 12 cycles, never overlapping `scan_enable`, then `done`, `timeout`=0.
- **Watchdog:** built with `SCAN_SEQ_WATCHDOG_EN`, `RUN_LIMIT`=20, `halt` never asserted → `proc_en` high 20 cycles, `timeout`=1 sticky, cleared by the next `start`. Repeat with `halt` asserted on cycle 20 → `timeout`=0.
- **Reset mid-session:** `rst` pulsed during bit 4 of byte 1 → next cycle all outputs are at reset values and `busy`=0. A following full session completes correctly.
- **Ignored start:** `start` pulsed during SHIFT and during RUN → no state change, byte count unaffected.

Source files
------------

// File: rtl/scan_sequencer.sv
// Scan-chain load/unload and run controller: streams bytes into a serial scan chain while capturing the outgoing bits.
// Optional RUN watchdog is enabled with the SCAN_SEQ_WATCHDOG_EN macro.
module scan_sequencer #(
    parameter int CHAIN_LEN = 2136,
    parameter int RUN_LIMIT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       run_req,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       scan_enable,
    output logic       scan_in,
    input  logic       scan_out,
    output logic       proc_en,
    input  logic       halt,
    output logic       busy,
    output logic       done,
    output logic       timeout
);

    localparam int NBYTES = CHAIN_LEN / 8;
    localparam int CW = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;

    logic [2:0]    state;
    logic          run_lat;
    logic [CW-1:0] byte_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    capreg;
    logic [7:0]    dout_q;
    logic          done_q;
    logic          wd_fire;

`ifdef SCAN_SEQ_WATCHDOG_EN
    localparam int RCW = $clog2(RUN_LIMIT + 1);
    localparam logic [RCW-1:0] RUN_LAST = RCW'(RUN_LIMIT - 1);

    logic [RCW-1:0] run_cnt;
    logic           timeout_q;

    // run_cnt holds the number of RUN cycles already completed, so it fires on the RUN_LIMIT-th cycle
    assign wd_fire = (state == S_RUN) && (run_cnt == RUN_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            run_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                timeout_q <= 1'b0;
            end else if (wd_fire && !halt) begin
                timeout_q <= 1'b1;
            end
            if (state == S_RUN) begin
                run_cnt <= run_cnt + 1'b1;
            end else begin
                run_cnt <= '0;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            run_lat  <= 1'b0;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            capreg   <= '0;
            dout_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_FETCH;
                        run_lat  <= run_req;
                        byte_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (din_valid) begin
                        shreg   <= din;
                        bit_cnt <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // scan_out is the pre-shift chain tail; first bit out ends in bit 0
                    shreg   <= {1'b0, shreg[7:1]};
                    capreg  <= {scan_out, capreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        dout_q <= {scan_out, capreg[7:1]};
                        state  <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (dout_ready) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            if (run_lat) begin
                                state <= S_RUN;
                            end else begin
                                state  <= S_IDLE;
                                done_q <= 1'b1;
                            end
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_RUN: begin
                    if (halt || wd_fire) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign din_ready   = (state == S_FETCH);
    assign dout_valid  = (state == S_DRAIN);
    assign scan_enable = (state == S_SHIFT);
    assign scan_in     = (state == S_SHIFT) && shreg[0];
    assign proc_en     = (state == S_RUN);
    assign busy        = (state != S_IDLE);
    assign dout        = dout_q;
    assign done        = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: behavioural scan-chain core plus session-level reference expectations.
// Watchdog sessions are included when SCAN_SEQ_WATCHDOG_EN is defined.
module tb_scan_sequencer;

    localparam int CHAIN_LEN = 16;
    localparam int NBYTES    = CHAIN_LEN / 8;
    localparam int RUN_LIMIT = 20;

`ifdef SCAN_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       run_req;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       scan_enable;
    logic       scan_in;
    logic       scan_out;
    logic       proc_en;
    logic       halt = 1'b0;
    logic       busy;
    logic       done;
    logic       timeout;

    int checks = 0;
    int failures = 0;

    logic [CHAIN_LEN-1:0] chain;
    logic [CHAIN_LEN-1:0] preload_val;
    logic                 preload_req;
    logic [7:0]           load_bytes[NBYTES];
    int                   halt_mode;
    int                   halt_after;
    int                   run_seen = 0;
    logic [15:0]          out_vec;

    scan_sequencer #(
        .CHAIN_LEN(CHAIN_LEN),
        .RUN_LIMIT(RUN_LIMIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .run_req(run_req),
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .scan_enable(scan_enable),
        .scan_in(scan_in),
        .scan_out(scan_out),
        .proc_en(proc_en),
        .halt(halt),
        .busy(busy),
        .done(done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    assign out_vec = {din_ready, dout, dout_valid, scan_enable, scan_in, proc_en, busy, done, timeout};

    // Core scan chain: shifts toward bit 0, new bits enter at the top
    assign scan_out = chain[0];
    always @(posedge clk) begin
        if (preload_req) chain <= preload_val;
        else if (scan_enable) chain <= {scan_in, chain[CHAIN_LEN-1:1]};
    end

    // Core halt model: mode 1 raises halt on the halt_after-th RUN cycle, mode 2 holds it high
    always @(negedge clk) begin
        run_seen = proc_en ? run_seen + 1 : 0;
        case (halt_mode)
            1:       halt = proc_en && (run_seen >= halt_after);
            2:       halt = 1'b1;
            default: halt = 1'b0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic rr, input int hmode, input int hafter,
                                 input int din_stall, input int dout_stall, input int rst_bit,
                                 input bit inject_start, input logic [CHAIN_LEN-1:0] pre);
        logic [7:0]           exp_out[NBYTES];
        logic [CHAIN_LEN-1:0] exp_chain;
        int idx = 0, oidx = 0, busy_cyc = 0, pe_cyc = 0, overlap = 0, stall_se = 0;
        int shifts = 0, fw = 0, dw = 0, pe_exp = 0;
        bit finished = 0, rst_pending = 0, was_reset = 0;

        for (int i = 0; i < NBYTES; i++) begin
            exp_out[i] = pre[8*i +: 8];
            exp_chain[8*i +: 8] = load_bytes[i];
        end
        if (rr) begin
            if (hmode == 2) pe_exp = 1;
            else if (hmode == 1) pe_exp = (WD_EN && hafter > RUN_LIMIT) ? RUN_LIMIT : hafter;
            else pe_exp = RUN_LIMIT;
        end

        @(negedge clk);
        preload_val = pre;
        preload_req = 1'b1;
        halt_mode   = hmode;
        halt_after  = hafter;
        @(negedge clk);
        preload_req = 1'b0;
        start   = 1'b1;
        run_req = rr;

        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            rst   = 1'b0;
            if (rst_pending) begin
                checkOutput({tag, "_reset_outputs"}, 32'(out_vec), 32'd0);
                was_reset = 1;
                break;
            end
            if (cyc == 0) checkOutput({tag, "_timeout_cleared"}, 32'(timeout), 32'd0);
            if (busy) busy_cyc++;
            if (proc_en) pe_cyc++;
            if (proc_en && scan_enable) overlap++;
            if (done) finished = 1;
            if (scan_enable) begin
                shifts++;
                if (inject_start && shifts == 3) begin
                    start   = 1'b1;
                    run_req = !rr;
                end
                if (rst_bit >= 0 && shifts == 8 + rst_bit + 1) begin
                    rst = 1'b1;
                    rst_pending = 1;
                end
            end
            if (proc_en && inject_start && pe_cyc == 2) start = 1'b1;

            if (idx < NBYTES) begin
                din = load_bytes[idx];
                if (din_ready && idx == 1 && fw < din_stall) begin
                    din_valid = 1'b0;
                    fw++;
                    if (scan_enable) stall_se++;
                end else begin
                    din_valid = 1'b1;
                end
            end else begin
                din_valid = 1'b0;
            end
            if (din_valid && din_ready) idx++;

            if (dout_valid && oidx == 0 && dw < dout_stall) begin
                dout_ready = 1'b0;
                dw++;
                if (scan_enable) stall_se++;
            end else begin
                dout_ready = 1'b1;
            end
            if (dout_valid && dout_ready) begin
                if (oidx < NBYTES) checkOutput($sformatf("%s_dout%0d", tag, oidx), 32'(dout), 32'(exp_out[oidx]));
                else checkOutput({tag, "_extra_dout"}, oidx, NBYTES - 1);
                oidx++;
            end
        end

        din_valid  = 1'b0;
        dout_ready = 1'b0;
        if (was_reset) return;
        if (!finished) begin
            checkOutput({tag, "_finish"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({tag, "_byte_count"}, oidx, NBYTES);
        checkOutput({tag, "_chain"}, 32'(chain), 32'(exp_chain));
        checkOutput({tag, "_busy_cycles"}, busy_cyc, 10 * NBYTES + din_stall + dout_stall + pe_exp);
        checkOutput({tag, "_proc_en_cycles"}, pe_cyc, pe_exp);
        checkOutput({tag, "_overlap"}, overlap, 0);
        checkOutput({tag, "_stall_shift"}, stall_se, 0);
        checkOutput({tag, "_timeout"}, 32'(timeout), 32'(WD_EN && rr && hmode == 0));
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; run_req = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
        preload_req = 1'b0; preload_val = '0; halt_mode = 0; halt_after = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 32'(out_vec), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_outputs", 32'(out_vec), 32'd0);

        load_bytes[0] = 8'h3C;
        load_bytes[1] = 8'hC3;
        applyStimulus("basic", 1'b0, 0, 0, 0, 0, -1, 1'b0, 16'hA55A);
        applyStimulus("backpressure", 1'b0, 0, 0, 5, 7, -1, 1'b0, 16'hA55A);
        applyStimulus("run_halt", 1'b1, 1, 12, 0, 0, -1, 1'b0, 16'h1234);
        applyStimulus("halt_preset", 1'b1, 2, 0, 0, 0, -1, 1'b0, 16'h0FF0);
`ifdef SCAN_SEQ_WATCHDOG_EN
        applyStimulus("watchdog", 1'b1, 0, 0, 0, 0, -1, 1'b0, 16'hBEEF);
        repeat (3) @(negedge clk);
        checkOutput("timeout_sticky", 32'(timeout), 32'd1);
        applyStimulus("wd_halt_at_limit", 1'b1, 1, 20, 0, 0, -1, 1'b0, 16'h5AA5);
`endif
        load_bytes[0] = 8'h96;
        load_bytes[1] = 8'h71;
        applyStimulus("reset_mid", 1'b0, 0, 0, 0, 0, 4, 1'b0, 16'hCAFE);
        applyStimulus("after_reset", 1'b0, 0, 0, 0, 0, -1, 1'b0, 16'h8001);
        applyStimulus("ignored_start", 1'b1, 1, 5, 0, 0, -1, 1'b1, 16'h7E18);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NBYTES; i++) load_bytes[i] = 8'($urandom);
            applyStimulus($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1, int'($urandom_range(1, 15)),
                          int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), -1, 1'b0,
                          CHAIN_LEN'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
